// File: rtl/cfs_synch_filt.sv
// cfs_synch_filt: per-channel multi-flop synchronizer with a persistence
// filter and registered rise/fall/changed pulses.
module cfs_synch_filt #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    STAGES        = 2,
    parameter int                    FILTER_CYCLES = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i,
    output logic [DATA_WIDTH-1:0] o,
    output logic [DATA_WIDTH-1:0] o_rise,
    output logic [DATA_WIDTH-1:0] o_fall,
    output logic                  o_changed
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $error("cfs_synch_filt: STAGES must be in 2..8");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 16) begin : g_bad_filter
        $error("cfs_synch_filt: FILTER_CYCLES must be in 1..16");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("cfs_synch_filt: DATA_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] stage_q [STAGES];
    logic [DATA_WIDTH-1:0] sync;
    logic [CW-1:0]         cnt_q   [DATA_WIDTH];
    logic [CW-1:0]         cnt_d   [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] o_d;
    logic [DATA_WIDTH-1:0] rise_d;
    logic [DATA_WIDTH-1:0] fall_d;

    assign sync = stage_q[STAGES-1];

    // Synchronizer chain: stage 0 samples i, each later stage its predecessor.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    // Filter decision: a differing value must persist FILTER_CYCLES edges.
    always_comb begin
        o_d    = o;
        rise_d = '0;
        fall_d = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            cnt_d[k] = '0;
            if (sync[k] != o[k]) begin
                if (cnt_q[k] == CMAX) begin
                    o_d[k]    = sync[k];
                    rise_d[k] = sync[k];
                    fall_d[k] = ~sync[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Filtered outputs, counters and edge pulses all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            o         <= RESET_VALUE;
            o_rise    <= '0;
            o_fall    <= '0;
            o_changed <= 1'b0;
            for (int k = 0; k < DATA_WIDTH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            o         <= o_d;
            o_rise    <= rise_d;
            o_fall    <= fall_d;
            o_changed <= |(rise_d | fall_d);
            for (int k = 0; k < DATA_WIDTH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cfs_synch_filt.sv
// tb_cfs_synch_filt: scoreboard bench for cfs_synch_filt, two parameter
// sets driven side by side against a window-based reference model.
module tb_cfs_synch_filt;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] f;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       ra, rb;
    logic [3:0] xa, xb;
    logic [3:0] oa, rsa, fla, ob, rsb, flb;
    logic       cha, chb;

    int vectors = 0;
    int miscompares = 0;

    exp_t qa[$];
    exp_t qb[$];

    logic [3:0] m_pipe [2][8];
    logic [3:0] m_hist [2][16];
    int         m_hn   [2];
    logic [3:0] m_o    [2];

    always #5 clk = ~clk;

    cfs_synch_filt #(
        .DATA_WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'h0)
    ) dut_a (
        .clk(clk), .reset(ra), .i(xa), .o(oa),
        .o_rise(rsa), .o_fall(fla), .o_changed(cha)
    );

    cfs_synch_filt #(
        .DATA_WIDTH(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(4'h0)
    ) dut_b (
        .clk(clk), .reset(rb), .i(xb), .o(ob),
        .o_rise(rsb), .o_fall(flb), .o_changed(chb)
    );

    // Reference: o flips a bit once the last fc synchronized samples all
    // disagree with it; sync is the input delayed by st edges.
    function automatic exp_t step(input int id, input int st, input int fc,
                                  input logic rst, input logic [3:0] x);
        exp_t       e;
        logic [3:0] s;
        logic [3:0] nw;
        logic       all;
        e = '0;
        if (rst) begin
            for (int j = 0; j < 8; j++) m_pipe[id][j] = 4'h0;
            m_hn[id] = 0;
            m_o[id]  = 4'h0;
            return e;
        end
        s = m_pipe[id][st-1];
        if (m_hn[id] == fc) begin
            for (int j = 0; j < fc - 1; j++) m_hist[id][j] = m_hist[id][j+1];
            m_hist[id][fc-1] = s;
        end else begin
            m_hist[id][m_hn[id]] = s;
            m_hn[id]++;
        end
        nw = m_o[id];
        for (int b = 0; b < 4; b++) begin
            if (m_hn[id] == fc) begin
                all = 1'b1;
                for (int j = 0; j < fc; j++)
                    if (m_hist[id][j][b] == m_o[id][b]) all = 1'b0;
                if (all) nw[b] = ~m_o[id][b];
            end
        end
        e.o = nw;
        e.r = nw & ~m_o[id];
        e.f = ~nw & m_o[id];
        e.c = |(e.r | e.f);
        m_o[id] = nw;
        for (int j = st - 1; j > 0; j--) m_pipe[id][j] = m_pipe[id][j-1];
        m_pipe[id][0] = x;
        return e;
    endfunction

    // Model advances on every edge and queues the expected response.
    always @(posedge clk) begin
        qa.push_back(step(0, 2, 3, ra, xa));
        qb.push_back(step(1, 3, 1, rb, xb));
    end

    // Monitor: compare each registered response just after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                vectors++;
                if ({oa, rsa, fla, cha} !== e) begin
                    miscompares++;
                    $display("FAIL dutA t=%0t got o=%h r=%h f=%h c=%b want o=%h r=%h f=%h c=%b",
                             $time, oa, rsa, fla, cha, e.o, e.r, e.f, e.c);
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                vectors++;
                if ({ob, rsb, flb, chb} !== e) begin
                    miscompares++;
                    $display("FAIL dutB t=%0t got o=%h r=%h f=%h c=%b want o=%h r=%h f=%h c=%b",
                             $time, ob, rsb, flb, chb, e.o, e.r, e.f, e.c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ra = 1'b1;
        rb = 1'b1;
        xa = 4'hF;
        xb = 4'hF;
        @(posedge clk);
        #1;
        chk("rst_o", oa, 4'h0);
        chk("rst_pulse", rsa | fla | {3'b0, cha}, 4'h0);
        @(posedge clk);
        #1;
        chk("rst_o2", oa, 4'h0);
        chk("rst_pulse2", rsa | fla | {3'b0, cha}, 4'h0);
        @(negedge clk);
        ra = 1'b0;
        rb = 1'b0;
        xa = 4'h0;
        xb = 4'h0;
        hold(6);

        xa = 4'h1;
        xb = 4'h8;
        repeat (3) @(posedge clk);
        #1;
        chk("b_edge3_o", ob, 4'h0);
        @(posedge clk);
        #1;
        chk("a_edge4_o", oa, 4'h0);
        chk("b_edge4_o", ob, 4'h8);
        chk("b_edge4_rise", rsb, 4'h8);
        @(posedge clk);
        #1;
        chk("a_edge5_o", oa, 4'h1);
        chk("a_edge5_rise", rsa, 4'h1);
        chk("a_edge5_fall", fla, 4'h0);
        chk("a_edge5_chg", {3'b0, cha}, 4'h1);
        @(posedge clk);
        #1;
        chk("a_edge6_rise", rsa, 4'h0);
        chk("a_edge6_chg", {3'b0, cha}, 4'h0);
        @(negedge clk);
        hold(4);

        xa = 4'h3;
        hold(2);
        xa = 4'h1;
        hold(8);
        chk("glitch_o", oa, 4'h1);

        xa = 4'h4;
        repeat (5) @(posedge clk);
        #1;
        chk("swap_o", oa, 4'h4);
        chk("swap_rise", rsa, 4'h4);
        chk("swap_fall", fla, 4'h1);
        @(negedge clk);
        hold(4);

        xa = 4'h0;
        hold(8);
        xa = 4'h1;
        hold(2);
        ra = 1'b1;
        hold(1);
        ra = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_o4", oa, 4'h0);
        @(posedge clk);
        #1;
        chk("rst_mid_o5", oa, 4'h1);
        chk("rst_mid_rise", rsa, 4'h1);
        @(negedge clk);
        hold(4);

        for (int n = 0; n < 400; n++) begin
            xa = xa ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            xb = xb ^ (4'($urandom) & 4'($urandom));
            ra = ($urandom_range(0, 39) == 0);
            rb = ($urandom_range(0, 39) == 0);
            hold(1);
        end
        ra = 1'b0;
        rb = 1'b0;
        hold(12);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
